// File: rtl/result_save_ctrl.sv
// Result save controller: arbitrates GEMM result writes (overwrite or accumulate)
// against readout requests and sequences the single-port result RAM.
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef RESULT_SIZE
`define RESULT_SIZE 32
`endif

module result_save_ctrl #(
  parameter int unsigned ADDR_W = `ADDR_SIZE,
  parameter int unsigned DATA_W = `RESULT_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_acc,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StAccRd,
    StAccWr,
    StRdIssue,
    StRdRet
  } state_e;

  state_e            state_q;
  logic              last_rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic idle;
  logic grant_wr;
  logic grant_rd;

  // Outputs are gated by rst so a reset cycle never writes RAM or pulses rd_data_valid.
  assign idle     = (state_q == StIdle) && !rst;
  assign grant_wr = wr_valid && (!rd_valid || last_rd_q);
  assign grant_rd = rd_valid && !grant_wr;
  assign wr_ready = idle && grant_wr;
  assign rd_ready = idle && grant_rd;
  assign busy     = !rst && (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_rd_q <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (wr_ready) begin
            addr_q    <= wr_addr;
            data_q    <= wr_data;
            last_rd_q <= 1'b0;
            state_q   <= wr_acc ? StAccRd : StWr;
          end else if (rd_ready) begin
            addr_q    <= rd_addr;
            last_rd_q <= 1'b1;
            state_q   <= StRdIssue;
          end
        end
        StAccRd:   state_q <= StAccWr;
        StRdIssue: state_q <= StRdRet;
        StWr, StAccWr, StRdRet: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_din       = '0;
    rd_data_valid = 1'b0;
    rd_data       = '0;
    if (!rst) begin
      unique case (state_q)
        StWr: begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = addr_q;
          ram_din  = data_q;
        end
        StAccRd, StRdIssue: begin
          ram_en   = 1'b1;
          ram_addr = addr_q;
        end
        StAccWr: begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = addr_q;
          ram_din  = ram_dout + data_q;  // wraps modulo 2^DATA_W
        end
        StRdRet: begin
          rd_data_valid = 1'b1;
          rd_data       = ram_dout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_save_ctrl.sv
// Randomised scoreboard bench for result_save_ctrl with a transaction-level memory model.
module tb_result_save_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NA = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_acc = 1'b0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_data_valid;
  logic [DW-1:0] rd_data;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic          busy;

  result_save_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_acc       (wr_acc),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_addr      (rd_addr),
    .rd_data_valid(rd_data_valid),
    .rd_data      (rd_data),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench-side RAM with a registered read port.
  logic [DW-1:0] mem [NA];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout      <= mem[ram_addr];
    end
  end

  typedef struct {
    bit          is_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] old;
    int            at;
  } ev_t;

  ev_t           q[$];
  logic [DW-1:0] gold [NA];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cnt = 0;
  bit            last_rd = 1'b1;
  bit            acc_w = 1'b0;
  bit            acc_r = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_%s: addr %0h data %0h (cycle %0d)", rd ? "rd" : "wr", a, d, cyc);
    end else begin
      e = q.pop_front();
      check("ev_kind", 64'(rd), 64'(e.is_rd));
      check("ev_cycle", 64'(cyc), 64'(e.at));
      if (!rd) check("wr_addr", 64'(a), 64'(e.addr));
      check(rd ? "rd_data" : "wr_din", 64'(d), 64'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (ram_en && ram_we) mon(1'b0, ram_addr, ram_din);
    if (rd_data_valid)    mon(1'b1, '0, rd_data);
  end

  // One cycle of the reference model: predicts grants, busy and future RAM/readout events.
  task automatic step();
    logic gw, gr;
    ev_t  e;
    @(negedge clk);
    acc_w = 1'b0;
    acc_r = 1'b0;
    if (rst) begin
      check("reset_outputs", 64'({wr_ready, rd_ready, rd_data_valid, ram_en, ram_we, busy,
                                  ram_addr, ram_din, rd_data}), 64'd0);
      while (q.size() != 0) begin
        e = q.pop_back();
        if (!e.is_rd) gold[e.addr] = e.old;
      end
      cnt     = 0;
      last_rd = 1'b1;
    end else begin
      check("busy", 64'(busy), 64'(cnt != 0));
      gw = (cnt == 0) && wr_valid && (!rd_valid || last_rd);
      gr = (cnt == 0) && rd_valid && !gw;
      check("wr_ready", 64'(wr_ready), 64'(gw));
      check("rd_ready", 64'(rd_ready), 64'(gr));
      if (cnt != 0) begin
        cnt--;
      end else if (gw) begin
        e.is_rd = 1'b0;
        e.addr  = wr_addr;
        e.old   = gold[wr_addr];
        e.data  = wr_acc ? DW'(gold[wr_addr] + wr_data) : wr_data;
        e.at    = cyc + (wr_acc ? 2 : 1);
        gold[wr_addr] = e.data;
        q.push_back(e);
        cnt     = wr_acc ? 2 : 1;
        last_rd = 1'b0;
        acc_w   = 1'b1;
      end else if (gr) begin
        e.is_rd = 1'b1;
        e.addr  = rd_addr;
        e.old   = '0;
        e.data  = gold[rd_addr];
        e.at    = cyc + 2;
        q.push_back(e);
        cnt     = 2;
        last_rd = 1'b1;
        acc_r   = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit acc);
    bit done = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_acc   = acc;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = acc_w;
    end
    wr_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wr_accept_timeout: got no handshake expected one within 20 cycles");
    end
  endtask

  task automatic do_rd(input logic [AW-1:0] a);
    bit done = 1'b0;
    rd_valid = 1'b1;
    rd_addr  = a;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = acc_r;
    end
    rd_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rd_accept_timeout: got no handshake expected one within 20 cycles");
    end
  endtask

  initial begin
    for (int i = 0; i < NA; i++) begin
      mem[i]  = '0;
      gold[i] = '0;
    end
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    // Overwrite, accumulate, readout and wrap-around.
    do_wr(4'd5, 8'h10, 1'b0);
    idle(2);
    do_wr(4'd5, 8'h03, 1'b1);
    idle(3);
    check("mem5_accum", 64'(mem[5]), 64'h13);
    do_rd(4'd5);
    idle(3);
    do_wr(4'd7, 8'hFF, 1'b0);
    idle(2);
    do_wr(4'd7, 8'h02, 1'b1);
    idle(3);
    check("mem7_wrap", 64'(mem[7]), 64'h01);
    do_rd(4'd7);
    idle(3);

    // Contention from reset: both requesters held valid, grants must alternate.
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 4'd9;
    wr_acc   = 1'b0;
    wr_data  = DW'($urandom);
    rd_valid = 1'b1;
    rd_addr  = 4'd9;
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (acc_w) wr_data = DW'($urandom);
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    idle(4);

    // Reset while the accumulate read is in flight must leave memory untouched.
    do_wr(4'd3, 8'h20, 1'b0);
    idle(2);
    do_wr(4'd3, 8'h05, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(3);
    check("abort_mem3", 64'(mem[3]), 64'h20);
    do_rd(4'd3);
    idle(3);

    // Random traffic with payload changes while pending and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (!wr_valid && $urandom_range(0, 2) == 0) begin
        wr_valid = 1'b1;
        wr_addr  = AW'($urandom);
        wr_data  = DW'($urandom);
        wr_acc   = 1'($urandom);
      end else if (wr_valid && $urandom_range(0, 3) == 0) begin
        wr_data = DW'($urandom);
        wr_addr = AW'($urandom);
      end
      if (!rd_valid && $urandom_range(0, 2) == 0) begin
        rd_valid = 1'b1;
        rd_addr  = AW'($urandom);
      end else if (rd_valid && $urandom_range(0, 3) == 0) begin
        rd_addr = AW'($urandom);
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
      if (acc_w) wr_valid = 1'b0;
      if (acc_r) rd_valid = 1'b0;
      if (rst) begin
        wr_valid = 1'b0;
        rd_valid = 1'b0;
      end
    end
    rst      = 1'b0;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    idle(5);

    check("queue_drained", 64'(q.size()), 64'd0);
    for (int i = 0; i < NA; i++) check("final_mem", 64'(mem[i]), 64'(gold[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
